stack_mem_ctrl: RTL and testbench
=================================

Name: stack_mem_ctrl

Overview:
Sequencing controller for the 8-bit processor's data memory. It owns the stack pointer and executes LOAD/STORE (R0-addressed) and PUSH/POP/CALL/RET (SP-addressed) operations with a valid/ready handshake. It drives the memory's address-select (S2), data-select (S3) and WR controls, and returns read data tagged for the register file or the PC. The stack is empty-descending: SP points at the next free slot.

Parameters:
SP_RESET, 8'hFF, SP value after reset; empty-stack value.
STACK_LIMIT, 8'hC0, lowest legal stack slot. Must be >= 1. Capacity = SP_RESET-STACK_LIMIT+1 entries (64 by default).

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  operation request
op_code  in  3  000 NOP, 001 LOAD, 010 STORE, 011 PUSH, 100 POP, 101 CALL, 110 RET, 111 reserved (executes as NOP)
op_ready  out  1  controller can accept an op this cycle
sp_load  in  1  load SP from sp_wdata (LDSP); effective in IDLE only
sp_wdata  in  8  new SP value
err_clr  in  1  clears sticky error flags
mem_rdata  in  8  memory combinational read data (dataOut)
sp_out  out  8  stack address to memory SP_in
sel_sp  out  1  to S2: 1 = address from sp_out, 0 = R0
sel_reg  out  1  to S3: 1 = write data R_N, 0 = NPC
mem_wr  out  1  to WR
rd_data  out  8  captured read data; held until the next read
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_dest  out  1  0 = register file (LOAD/POP), 1 = PC (RET)
done  out  1  one-cycle pulse at op completion
sp  out  8  current SP, for debug/observation
err_ovf  out  1  sticky: PUSH/CALL attempted on a full stack
err_unf  out  1  sticky: POP/RET attempted on an empty stack

Behaviour:
- Reset (async, immediate): state=IDLE, SP=SP_RESET, rd_data=0, err_ovf=err_unf=0. All strobes (mem_wr, rd_valid, done) are 0; sel_sp=sel_reg=0; rd_dest=0.
- States: IDLE -> EXEC -> DONE -> IDLE. One op takes 3 cycles from acceptance; there is no back-to-back overlap.
- IDLE: op_ready = !sp_load.
  - sp_load=1: SP <= sp_wdata; no op accepted. sp_load has priority over a simultaneous op_valid.
  - op_valid & op_ready: latch op_code; go to EXEC.
  - sp_load outside IDLE is ignored.
- EXEC (one cycle; op_ready=0). The datapath holds R0/R_N/NPC stable while op_ready=0.
  - STORE: sel_sp=0, sel_reg=1, mem_wr=1.
  - LOAD: sel_sp=0, mem_wr=0; rd_data <= mem_rdata at the closing edge.
  - PUSH: if not full, sel_sp=1, sel_reg=1, mem_wr=1, sp_out=SP; SP <= SP-1.
  - CALL: as PUSH, but with sel_reg=0 (NPC is written).
  - POP/RET: if not empty, sel_sp=1, sp_out=SP+1; rd_data <= mem_rdata; SP <= SP+1.
  - NOP/reserved: no memory activity.
- DONE (op_ready=0): done=1. rd_valid=1 for LOAD, and for POP/RET that were not blocked. rd_dest=1 only for RET. Return to IDLE.
- sp_out equals SP in every state except EXEC of POP/RET.
- Full condition: SP == STACK_LIMIT-1. PUSH/CALL while full: mem_wr stays 0, SP unchanged, err_ovf <= 1, done still pulses.
- Empty condition: SP == SP_RESET. POP/RET while empty: SP unchanged, rd_data unchanged, rd_valid=0, err_unf <= 1, done still pulses.
- SP arithmetic is 8-bit modulo. The full/empty guards prevent wrap within the legal range. An sp_load outside the range is accepted unchecked.
- Error flags: set and err_clr in the same cycle -> set wins. err_clr clears both flags otherwise.
- Reset mid-operation: the op is abandoned. Any EXEC-cycle mem_wr drops asynchronously, no done is issued, and SP returns to SP_RESET.

Test Plan:
- Reset, then idle 5 cycles -> sp=FF, op_ready=1, mem_wr=0, done=0, err_ovf=err_unf=0.
- PUSH with R_N=5A -> EXEC: mem_wr=1, sel_sp=1, sel_reg=1, sp_out=FF; then sp=FE, done. Then POP -> EXEC sp_out=FF; DONE: rd_data=5A, rd_valid=1, rd_dest=0, sp=FF.
- CALL with NPC=23, then RET -> CALL EXEC: sel_reg=0, write at FF. RET DONE: rd_data=23, rd_dest=1, sp=FF.
- 64 PUSHes -> sp=BF. 65th PUSH -> mem_wr never asserted, sp=BF, err_ovf=1, done pulses. err_clr -> err_ovf=0.
- POP from reset -> rd_valid=0, sp=FF, err_unf=1, rd_data=00. STORE with R0=10, then LOAD R0=10 -> rd_data equals the stored R_N, sel_sp=0 throughout.
- sp_load=1 (sp_wdata=E0) with op_valid in the same cycle -> op_ready=0, sp=E0, op not executed. rst_n low during PUSH EXEC -> mem_wr falls immediately, sp=FF, no done.

Source files
------------

// File: rtl/stack_mem_ctrl.sv
// Data-memory sequencing controller for the 8-bit processor.
// Owns the empty-descending stack pointer (SP points at the next free slot) and
// runs LOAD/STORE (R0-addressed) and PUSH/POP/CALL/RET (SP-addressed) operations
// as a fixed IDLE -> EXEC -> DONE sequence.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   op_valid/op_code        operation request; op_ready accepts it (IDLE, no sp_load)
//   sp_load/sp_wdata        direct SP load, IDLE only, wins over op_valid
//   err_clr                 clears the sticky error flags
//   mem_rdata               combinational memory read data
//   sp_out, sel_sp, sel_reg, mem_wr   memory address/data select and write strobe
//   rd_data/rd_valid/rd_dest          captured read data, valid pulse, 1 = PC target
//   done                    completion pulse; sp is the current SP
//   err_ovf/err_unf         sticky push-on-full / pop-on-empty flags
module stack_mem_ctrl #(
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  output logic       op_ready,
  input  logic       sp_load,
  input  logic [7:0] sp_wdata,
  input  logic       err_clr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] sp_out,
  output logic       sel_sp,
  output logic       sel_reg,
  output logic       mem_wr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_dest,
  output logic       done,
  output logic [7:0] sp,
  output logic       err_ovf,
  output logic       err_unf
);

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_LOAD  = 3'b001;
  localparam logic [OPW-1:0] OP_STORE = 3'b010;
  localparam logic [OPW-1:0] OP_PUSH  = 3'b011;
  localparam logic [OPW-1:0] OP_POP   = 3'b100;
  localparam logic [OPW-1:0] OP_CALL  = 3'b101;
  localparam logic [OPW-1:0] OP_RET   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           blk_q, blk_d;
  logic [7:0]     sp_q, sp_d;
  logic [7:0]     sp_out_q, sp_out_d;
  logic           sel_sp_q, sel_sp_d;
  logic           sel_reg_q, sel_reg_d;
  logic           mem_wr_q, mem_wr_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_dest_q, rd_dest_d;
  logic           done_q, done_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_unf_q, err_unf_d;

  logic           full_c, empty_c;
  logic           pop_go, ovf_set, unf_set;

  assign full_c  = (sp_q == STACK_LIMIT - 8'd1);
  assign empty_c = (sp_q == SP_RESET);

  // Acceptance depends on the live sp_load input, so op_ready is combinational.
  assign op_ready = (state_q == ST_IDLE) && !sp_load;

  // Next-state and registered-output decode. Memory controls for EXEC are
  // decided at acceptance so they appear as clean flop outputs in EXEC; the
  // full/empty verdict is latched in blk_q since SP cannot move in between.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    blk_d      = blk_q;
    sp_d       = sp_q;
    sel_sp_d   = 1'b0;
    sel_reg_d  = 1'b0;
    mem_wr_d   = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_dest_d  = 1'b0;
    done_d     = 1'b0;
    pop_go     = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sp_load) begin
          sp_d = sp_wdata;
        end else if (op_valid) begin
          state_d = ST_EXEC;
          op_d    = op_code;
          blk_d   = 1'b0;
          case (op_code)
            OP_STORE: begin
              sel_reg_d = 1'b1;
              mem_wr_d  = 1'b1;
            end
            OP_PUSH, OP_CALL: begin
              if (full_c) begin
                blk_d = 1'b1;
              end else begin
                sel_sp_d  = 1'b1;
                sel_reg_d = (op_code == OP_PUSH);
                mem_wr_d  = 1'b1;
              end
            end
            OP_POP, OP_RET: begin
              if (empty_c) begin
                blk_d = 1'b1;
              end else begin
                sel_sp_d = 1'b1;
                pop_go   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      ST_EXEC: begin
        state_d   = ST_DONE;
        done_d    = 1'b1;
        rd_dest_d = (op_q == OP_RET);
        case (op_q)
          OP_LOAD: begin
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
          end
          OP_PUSH, OP_CALL: begin
            if (blk_q) ovf_set = 1'b1;
            else       sp_d    = sp_q - 8'd1;
          end
          OP_POP, OP_RET: begin
            if (blk_q) begin
              unf_set = 1'b1;
            end else begin
              rd_data_d  = mem_rdata;
              rd_valid_d = 1'b1;
              sp_d       = sp_q + 8'd1;
            end
          end
          default: ;
        endcase
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // POP/RET read the last occupied slot, one above SP, during EXEC only.
    sp_out_d  = pop_go ? (sp_q + 8'd1) : sp_d;

    // A new error in the same cycle as err_clr wins.
    err_ovf_d = ovf_set | (err_ovf_q & ~err_clr);
    err_unf_d = unf_set | (err_unf_q & ~err_clr);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      blk_q      <= 1'b0;
      sp_q       <= SP_RESET;
      sp_out_q   <= SP_RESET;
      sel_sp_q   <= 1'b0;
      sel_reg_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_dest_q  <= 1'b0;
      done_q     <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      blk_q      <= blk_d;
      sp_q       <= sp_d;
      sp_out_q   <= sp_out_d;
      sel_sp_q   <= sel_sp_d;
      sel_reg_q  <= sel_reg_d;
      mem_wr_q   <= mem_wr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_dest_q  <= rd_dest_d;
      done_q     <= done_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

  assign sp_out   = sp_out_q;
  assign sel_sp   = sel_sp_q;
  assign sel_reg  = sel_reg_q;
  assign mem_wr   = mem_wr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_dest  = rd_dest_q;
  assign done     = done_q;
  assign sp       = sp_q;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl: a vector table of single operations
// with hand-computed results, plus hand-written overflow, underflow, sp_load
// priority and reset-during-EXEC sequences. A small memory and datapath model
// (R0/R_N/NPC registers, S2/S3 muxes) sits around the controller.
module tb_stack_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic       sp_load;
  logic [7:0] sp_wdata;
  logic       err_clr;
  logic [7:0] mem_rdata;
  logic [7:0] sp_out;
  logic       sel_sp, sel_reg, mem_wr;
  logic [7:0] rd_data;
  logic       rd_valid, rd_dest, done;
  logic [7:0] sp;
  logic       err_ovf, err_unf;

  logic [7:0] r0, rn, npc;
  logic [7:0] mem [256];
  logic [7:0] addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stack_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .sp_load(sp_load), .sp_wdata(sp_wdata),
    .err_clr(err_clr), .mem_rdata(mem_rdata), .sp_out(sp_out),
    .sel_sp(sel_sp), .sel_reg(sel_reg), .mem_wr(mem_wr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_dest(rd_dest), .done(done), .sp(sp),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // Datapath model: S2 picks the address, S3 the write data.
  assign addr      = sel_sp ? sp_out : r0;
  assign mem_rdata = mem[addr];
  always @(posedge clk) if (mem_wr) mem[addr] <= sel_reg ? rn : npc;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3,
                         POP = 3'd4, CALL = 3'd5, RET = 3'd6, RSVD = 3'd7;

  // Observed values from the last run_op
  logic       o_ready, o_wr, o_sel_sp, o_sel_reg, o_done, o_rv, o_rdst, o_ovf, o_unf;
  logic [7:0] o_sp_out, o_rd, o_sp;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one op and samples the EXEC and DONE cycles on falling edges.
  task automatic run_op(input logic [2:0] op, input logic [7:0] r0v,
                        input logic [7:0] rnv, input logic [7:0] npcv);
    @(negedge clk);
    r0 = r0v; rn = rnv; npc = npcv;
    op_valid = 1'b1; op_code = op;
    #1 o_ready = op_ready;
    @(negedge clk);
    op_valid = 1'b0; op_code = NOP;
    o_wr = mem_wr; o_sel_sp = sel_sp; o_sel_reg = sel_reg; o_sp_out = sp_out;
    @(negedge clk);
    o_done = done; o_rv = rd_valid; o_rd = rd_data; o_rdst = rd_dest;
    o_sp = sp; o_ovf = err_ovf; o_unf = err_unf;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] r0, rn, npc;
    logic       e_wr, e_sel_sp, e_sel_reg;
    logic [7:0] e_sp_out;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_rdst;
    logic [7:0] e_sp;
    logic       e_unf;
  } vec_t;

  vec_t vecs [9];

  initial begin
    rst_n = 1'b1; op_valid = 1'b0; op_code = NOP; sp_load = 1'b0;
    sp_wdata = 8'h00; err_clr = 1'b0; r0 = 8'h00; rn = 8'h00; npc = 8'h00;

    //          op     r0     rn     npc   wr sel_sp sel_reg sp_out rv rd     rdst sp     unf
    vecs[0] = '{PUSH,  8'h00, 8'h5A, 8'h00, 1, 1, 1, 8'hFF, 0, 8'h00, 0, 8'hFE, 0};
    vecs[1] = '{POP,   8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 1, 8'h5A, 0, 8'hFF, 0};
    vecs[2] = '{CALL,  8'h00, 8'h99, 8'h23, 1, 1, 0, 8'hFF, 0, 8'h5A, 0, 8'hFE, 0};
    vecs[3] = '{RET,   8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 1, 8'h23, 1, 8'hFF, 0};
    vecs[4] = '{POP,   8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 0, 8'h23, 0, 8'hFF, 1};
    vecs[5] = '{STORE, 8'h10, 8'h77, 8'h00, 1, 0, 1, 8'hFF, 0, 8'h23, 0, 8'hFF, 1};
    vecs[6] = '{LOAD,  8'h10, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 1, 8'h77, 0, 8'hFF, 1};
    vecs[7] = '{NOP,   8'h10, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 0, 8'h77, 0, 8'hFF, 1};
    vecs[8] = '{RSVD,  8'h10, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 0, 8'h77, 0, 8'hFF, 1};

    // Reset state after 5 idle cycles
    do_reset();
    repeat (5) @(negedge clk);
    chk("rst_sp", sp, 8'hFF);
    chk("rst_ready", 8'(op_ready), 8'h1);
    chk("rst_wr", 8'(mem_wr), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_ovf", 8'(err_ovf), 8'h0);
    chk("rst_unf", 8'(err_unf), 8'h0);
    chk("rst_rd", rd_data, 8'h00);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].r0, vecs[i].rn, vecs[i].npc);
      chk($sformatf("v%0d_ready", i), 8'(o_ready), 8'h1);
      chk($sformatf("v%0d_wr", i), 8'(o_wr), 8'(vecs[i].e_wr));
      chk($sformatf("v%0d_sel_sp", i), 8'(o_sel_sp), 8'(vecs[i].e_sel_sp));
      if (vecs[i].e_wr) chk($sformatf("v%0d_sel_reg", i), 8'(o_sel_reg), 8'(vecs[i].e_sel_reg));
      chk($sformatf("v%0d_sp_out", i), o_sp_out, vecs[i].e_sp_out);
      chk($sformatf("v%0d_done", i), 8'(o_done), 8'h1);
      chk($sformatf("v%0d_rd_valid", i), 8'(o_rv), 8'(vecs[i].e_rv));
      chk($sformatf("v%0d_rd_data", i), o_rd, vecs[i].e_rd);
      chk($sformatf("v%0d_rd_dest", i), 8'(o_rdst), 8'(vecs[i].e_rdst));
      chk($sformatf("v%0d_sp", i), o_sp, vecs[i].e_sp);
      chk($sformatf("v%0d_unf", i), 8'(o_unf), 8'(vecs[i].e_unf));
      chk($sformatf("v%0d_ovf", i), 8'(o_ovf), 8'h0);
    end

    // err_clr clears the underflow flag
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_unf", 8'(err_unf), 8'h0);

    // Fill the stack: 64 pushes
    for (int i = 0; i < 64; i++) begin
      run_op(PUSH, 8'h00, 8'(i + 8'h40), 8'h00);
      chk($sformatf("fill%0d_wr", i), 8'(o_wr), 8'h1);
      chk($sformatf("fill%0d_sp", i), o_sp, 8'(8'hFE - i));
    end
    chk("full_sp", sp, 8'hBF);
    chk("full_top_mem", mem[8'hC0], 8'h7F);

    // 65th push is blocked: no write anywhere in the op, flag set, done still pulses
    @(negedge clk);
    op_valid = 1'b1; op_code = PUSH; rn = 8'hEE;
    begin
      logic wr_seen = 1'b0;
      logic dn_seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        op_valid = 1'b0;
        wr_seen |= mem_wr;
        dn_seen |= done;
      end
      chk("ovf_wr_never", 8'(wr_seen), 8'h0);
      chk("ovf_done", 8'(dn_seen), 8'h1);
    end
    chk("ovf_sp", sp, 8'hBF);
    chk("ovf_flag", 8'(err_ovf), 8'h1);
    chk("ovf_mem_bf", mem[8'hBF] == 8'hEE ? 8'h1 : 8'h0, 8'h0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("ovf_clr", 8'(err_ovf), 8'h0);

    // POP straight after reset: blocked, rd_data stays at its reset value
    do_reset();
    run_op(POP, 8'h00, 8'h00, 8'h00);
    chk("unf_rv", 8'(o_rv), 8'h0);
    chk("unf_sp", o_sp, 8'hFF);
    chk("unf_flag", 8'(o_unf), 8'h1);
    chk("unf_rd", o_rd, 8'h00);
    chk("unf_done", 8'(o_done), 8'h1);

    // sp_load beats a simultaneous op_valid
    @(negedge clk);
    sp_load = 1'b1; sp_wdata = 8'hE0; op_valid = 1'b1; op_code = PUSH;
    #1 chk("ld_ready", 8'(op_ready), 8'h0);
    @(negedge clk);
    sp_load = 1'b0; op_valid = 1'b0; op_code = NOP;
    chk("ld_sp", sp, 8'hE0);
    begin
      logic act_seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        act_seen |= mem_wr | done;
      end
      chk("ld_no_exec", 8'(act_seen), 8'h0);
    end
    chk("ld_sp_held", sp, 8'hE0);

    // Reset during PUSH EXEC
    @(negedge clk);
    op_valid = 1'b1; op_code = PUSH; rn = 8'h11;
    @(negedge clk);
    op_valid = 1'b0; op_code = NOP;
    chk("rx_wr_exec", 8'(mem_wr), 8'h1);
    chk("rx_sp_out", sp_out, 8'hE0);
    rst_n = 1'b0;
    #1;
    chk("rx_wr_drop", 8'(mem_wr), 8'h0);
    chk("rx_sp", sp, 8'hFF);
    begin
      logic dn_seen = 1'b0;
      @(negedge clk); dn_seen |= done;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); dn_seen |= done;
      end
      chk("rx_no_done", 8'(dn_seen), 8'h0);
    end
    chk("rx_ready", 8'(op_ready), 8'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
